// File: rtl/p0011_result_uart.sv
// Result readout for the problem-11 solver: latches the answer on done, converts it
// to decimal with double-dabble and sends it (or "ERR") over an 8N1 UART, once per reset.
module p0011_result_uart #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        done,
  input  logic        error,
  output logic        tx,
  output logic        busy,
  output logic        sent
);

  localparam int unsigned BAUD_W  = 16;
  localparam int unsigned BCD_W   = 40;
  localparam int unsigned DIGITS  = 10;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CONVERT     = 3'd1,
    SKIP        = 3'd2,
    SEND_DIGITS = 3'd3,
    ERR_MSG     = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t            state, state_n;
  logic              tx_n, busy_n, sent_n;
  logic [BCD_W-1:0]  bcd, bcd_n, bcd_adj_c;
  logic [31:0]       sh, sh_n;
  logic [4:0]        cnt, cnt_n;
  logic [3:0]        ptr, ptr_n;
  logic [1:0]        tail, tail_n;
  logic [2:0]        pos, pos_n;
  logic              active, active_n;
  logic [3:0]        bit_idx, bit_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [3:0]        digit_c;
  logic [7:0]        char_c;
  logic              last_c;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign digit_c = bcd[{ptr, 2'b00} +: 4];

  // Character currently on the line; stable for the whole frame
  always_comb begin
    char_c = 8'h0A;
    if (state == ERR_MSG) begin
      case (pos)
        3'd0:    char_c = 8'h45;
        3'd1:    char_c = 8'h52;
        3'd2:    char_c = 8'h52;
        3'd3:    char_c = 8'h0D;
        default: char_c = 8'h0A;
      endcase
    end else begin
      case (tail)
        2'd0:    char_c = 8'h30 + {4'h0, digit_c};
        2'd1:    char_c = 8'h0D;
        default: char_c = 8'h0A;
      endcase
    end
  end

  assign last_c = (state == ERR_MSG) ? (pos == 3'd4) : (tail == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      sent    <= 1'b0;
      bcd     <= '0;
      sh      <= '0;
      cnt     <= '0;
      ptr     <= '0;
      tail    <= '0;
      pos     <= '0;
      active  <= 1'b0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      busy    <= busy_n;
      sent    <= sent_n;
      bcd     <= bcd_n;
      sh      <= sh_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      tail    <= tail_n;
      pos     <= pos_n;
      active  <= active_n;
      bit_idx <= bit_n;
      baud    <= baud_n;
    end
  end

  always_comb begin
    state_n  = state;
    tx_n     = tx;
    busy_n   = busy;
    sent_n   = sent;
    bcd_n    = bcd;
    sh_n     = sh;
    cnt_n    = cnt;
    ptr_n    = ptr;
    tail_n   = tail;
    pos_n    = pos;
    active_n = active;
    bit_n    = bit_idx;
    baud_n   = baud;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (done && !sent) begin
          sh_n     = result;
          bcd_n    = '0;
          cnt_n    = '0;
          ptr_n    = 4'd9;
          tail_n   = '0;
          pos_n    = '0;
          active_n = 1'b0;
          busy_n   = 1'b1;
          state_n  = error ? ERR_MSG : CONVERT;
        end
      end

      CONVERT: begin
        bcd_n = {bcd_adj_c[BCD_W-2:0], sh[31]};
        sh_n  = {sh[30:0], 1'b0};
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) begin
          ptr_n   = 4'd9;
          state_n = SKIP;
        end
      end

      SKIP: begin
        if (digit_c == 4'd0 && ptr != 4'd0) ptr_n = ptr - 4'd1;
        else                                state_n = SEND_DIGITS;
      end

      SEND_DIGITS, ERR_MSG: begin
        if (!active) begin
          active_n = 1'b1;
          tx_n     = 1'b0;
          bit_n    = '0;
          baud_n   = '0;
        end else if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 4'd9) begin
            if (last_c) begin
              state_n  = DONE;
              busy_n   = 1'b0;
              sent_n   = 1'b1;
              tx_n     = 1'b1;
              active_n = 1'b0;
            end else begin
              // Next character starts right after this stop bit
              if (state == ERR_MSG)                  pos_n  = pos + 3'd1;
              else if (tail == 2'd0 && ptr != 4'd0)  ptr_n  = ptr - 4'd1;
              else                                   tail_n = tail + 2'd1;
              tx_n  = 1'b0;
              bit_n = '0;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
            tx_n  = (bit_idx == 4'd8) ? 1'b1 : char_c[bit_idx[2:0]];
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end

      DONE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end

      default: begin
        state_n  = IDLE;
        tx_n     = 1'b1;
        busy_n   = 1'b0;
        active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_p0011_result_uart.sv
// Scoreboard bench: the stimulus pushes the expected ASCII bytes, a UART receiver
// monitor decodes tx and compares each received byte against the queue.
module tb_p0011_result_uart;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0;
  logic        done = 1'b0;
  logic        error = 1'b0;
  logic        tx, busy, sent;

  p0011_result_uart #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .result(result), .done(done), .error(error),
    .tx(tx), .busy(busy), .sent(sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];

  int   busy_cnt   = 0;
  int   want_first = 0;
  int   first_cyc  = 0;
  int   latch_cyc  = 0;
  int   exp_lat    = 0;
  int   exp_chars  = 0;
  int   rx_active  = 0;
  int   rx_cnt     = 0;
  int   rx_bytes   = 0;
  logic [7:0] rx_byte;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART receiver monitor: samples mid-bit on falling edges and scores each byte
  initial forever begin
    @(negedge clk);
    if (busy) busy_cnt++;
    if (rst) begin
      rx_active = 0;
    end else if (rx_active == 0) begin
      if (tx == 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
        rx_byte   = '0;
        if (want_first != 0) begin
          first_cyc  = cyc;
          want_first = 0;
        end
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2) begin
        int b;
        b = rx_cnt / C;
        if (b >= 1 && b <= 8) rx_byte[b-1] = tx;
        else if (b == 9) begin
          chk("stop_bit", 64'(tx), 64'd1);
          rx_bytes++;
          if (exp_q.size() == 0) chk("unexpected_byte", 64'(rx_byte), 64'h100);
          else chk("rx_byte", 64'(rx_byte), 64'(exp_q.pop_front()));
        end
      end
      if (rx_cnt == 10 * C - 1) rx_active = 0;
    end
  end

  // Reference model: decimal text from the number, fixed latency rules from the readout protocol
  task automatic expect_msg(input logic [31:0] r, input logic e);
    string s;
    if (e) s = "ERR";
    else   s = $sformatf("%0d", r);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_chars  = s.len() + 2;
    exp_lat    = e ? 1 : 1 + 32 + (10 - s.len()) + 1;
    busy_cnt   = 0;
    want_first = 1;
    latch_cyc  = cyc + 1;
  endtask

  task automatic wait_msg(input string tag, input int scramble);
    int n;
    n = 0;
    while (sent !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (scramble != 0 && n == 3) begin
        result = $urandom;
        error  = ~error;
      end
    end
    chk({tag, "_timeout"}, 64'(n < 2000), 64'd1);
    chk({tag, "_sent"}, 64'(sent), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_tx_idle"}, 64'(tx), 64'd1);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_latency"}, 64'(first_cyc - latch_cyc), 64'(exp_lat));
    chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_lat + exp_chars * 10 * C));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    done = 1'b0;
    exp_q.delete();
    want_first = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent", 64'(sent), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_msg(input string tag, input logic [31:0] r, input logic e, input int scramble);
    do_reset();
    result = r;
    error  = e;
    expect_msg(r, e);
    done = 1'b1;
    wait_msg(tag, scramble);
  endtask

  initial begin
    int n;
    int viol;
    rx_byte = '0;

    run_msg("dec", 32'd70600674, 1'b0, 1);
    run_msg("zero", 32'd0, 1'b0, 0);
    run_msg("max", 32'hFFFF_FFFF, 1'b0, 0);
    run_msg("err", 32'd12345, 1'b1, 1);

    // Reset in the middle of the third character, done left high
    do_reset();
    result = 32'd987654;
    error  = 1'b0;
    expect_msg(result, 1'b0);
    done = 1'b1;
    n = 0;
    while (!(rx_bytes >= 2 + (rx_bytes - rx_bytes) && rx_active != 0 && rx_cnt >= 12) && n < 2000) begin
      @(negedge clk);
      n++;
      if (rx_bytes < 2) n = n;
    end
    chk("midrst_reach", 64'(n < 2000), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx", 64'(tx), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sent", 64'(sent), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_msg(result, 1'b0);
    wait_msg("resend", 0);

    // No retransmission while done stays high
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || sent !== 1'b1) viol++;
    end
    chk("hold_quiet", 64'(viol), 64'd0);

    for (int k = 0; k < 8; k++) begin
      logic [31:0] r;
      logic        e;
      r = (k % 3 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      e = ($urandom_range(0, 3) == 0);
      run_msg($sformatf("rnd%0d", k), r, e, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p0011_result_uart.md
Name: p0011_result_uart

Overview:
- Downstream consumer of the problem-11 solver: waits for the solver's sticky done, latches result/error, converts the 32-bit binary result to decimal ASCII, and transmits it over a UART line followed by CR LF.
- On solver error, transmits the fixed string "ERR" CR LF instead.
- Transmits exactly once per reset; provides the board-level readout of the answer.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- result  input  32  solver result, unsigned binary; sampled only at latch.
- done  input  1  solver done, level, sticky high.
- error  input  1  solver error flag, valid when done=1.
- tx  output  1  UART transmit line, 8N1, idle high.
- busy  output  1  high from latch until the stop bit of LF completes.
- sent  output  1  high once the message is fully sent; sticky until rst.

Behaviour:
- Reset (async): tx=1, busy=0, sent=0, state=IDLE, baud counter, bit counter and BCD register cleared. Asserting rst mid-frame forces tx=1 immediately; the partial frame is abandoned.
- IDLE: if done=1 and sent=0 on a clock edge, latch result and error, busy<=1. Next state is ERR_MSG if error=1, else CONVERT. done sampled high while rst=1 is ignored; it is re-sampled on the first edge after release.
- CONVERT: double-dabble over a 40-bit BCD register (10 digits) plus a 32-bit shift register.
  - Exactly 32 cycles, one shift per cycle.
  - Before each shift, add 3 to every BCD nibble >= 5.
  - Then go to SKIP with the digit pointer at digit 9 (most significant).
- SKIP: one cycle per step. While the pointed digit is 0 and the pointer is > 0, decrement the pointer. Digit 0 is always sent, so a result of 0 prints "0". Worst case 9 cycles.
- SEND_DIGITS: send ASCII 0x30+digit for the pointer down to digit 0, then CR (0x0D), then LF (0x0A).
- ERR_MSG: send 0x45, 0x52, 0x52, 0x0D, 0x0A. The latched result is ignored.
- UART frame:
  - start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
  - Consecutive characters are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- Latency: the first start bit goes low no later than 43 cycles after the done-sampling edge (1 latch + 32 convert + up to 9 skip + 1). In ERR_MSG it goes low on the cycle after latch.
- DONE: after the LF stop bit, busy<=0 and sent<=1 on the same edge. tx stays 1. The block stays in DONE while done remains high; no retransmission until rst.
- Changes on result/error after latch have no effect.
- Illegal state encoding: go to IDLE with tx=1, busy=0, sent unchanged.

Test Plan (CLKS_PER_BIT=4 in simulation):
- result=70600674, error=0, done raised -> tx bytes 0x37 0x30 0x36 0x30 0x30 0x36 0x37 0x34 0x0D 0x0A. busy high for exactly 400 bit-clocks plus conversion/skip cycles. sent=1 afterwards.
- result=0 -> "0" CR LF (0x30 0x0D 0x0A); SKIP takes 9 cycles; sent=1.
- result=0xFFFFFFFF -> "4294967295" CR LF; no leading digit dropped; SKIP takes 0 cycles.
- error=1, result=12345 -> 0x45 0x52 0x52 0x0D 0x0A only.
- rst pulsed mid-way through the third character -> tx=1 in the same cycle, busy=0, sent=0. With done still high after release, the full message is resent from its first character.
- done held high for 10000 cycles after sent=1 -> tx stays 1 and busy stays 0; no second start bit.
